mem_io_port_unit: RTL and testbench
===================================

Name: mem_io_port_unit

Overview:
- Memory-stage address decoder and memory-mapped I/O block. Sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Consumes the EX/MEM ALU result (address), store data, MemRead and MemWrite.
- Either forwards the access to the data RAM or serves it from the I/O registers.
- Owns the 8-bit external input port (synchronized, change-detected) and the 32-bit output port.
- Returns read data toward the MEM/WB register.

Parameters:
- IO_BASE, 32'h1001_0400: word-aligned base of the 16-byte I/O window. Window is Address[31:4] == IO_BASE[31:4].
- IN_WIDTH, 8: width of the external input port.
- OUT_RESET, 32'h0000_0000: reset value of PORT_OUT.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-low reset
- Address  input  32  byte address from EX/MEM ALU result
- WriteData  input  32  store data from EX/MEM ReadData2
- MemRead  input  1  load strobe from EX/MEM control
- MemWrite  input  1  store strobe from EX/MEM control
- RAMReadData  input  32  read data returned by DataMemory
- PortIn  input  IN_WIDTH  asynchronous external input pins
- RAMMemRead  output  1  MemRead gated to the RAM
- RAMMemWrite  output  1  MemWrite gated to the RAM
- ReadData  output  32  load data to MEM/WB
- PortOut  output  32  registered output port
- InChanged  output  1  sticky "input changed" flag, level

Behaviour:
- Reset (reset==0 at a rising edge): all state resets as follows.
  - PORT_OUT = OUT_RESET.
  - Both synchronizer stages = 0; last-sample register = 0.
  - STATUS.changed = 0; EDGE_MASK = 8'hFF.
  - Reset has priority over any simultaneous access.
- Decode (combinational):
  - io_sel = (Address[31:4] == IO_BASE[31:4]).
  - RAMMemRead = MemRead & ~io_sel; RAMMemWrite = MemWrite & ~io_sel.
  - Address[1:0] is ignored (word access only).
- I/O register map, offset = Address[3:2]:
  - 0: PORT_OUT, R/W 32 bits.
  - 1: PORT_IN, RO, zero-extended synchronized input.
  - 2: STATUS, RO. bit0 = changed; bits31:1 = 0. Read clears bit0.
  - 3: EDGE_MASK, R/W, low IN_WIDTH bits; upper bits read 0.
- ReadData (combinational):
  - If MemRead & io_sel: selected register value.
  - Else if MemRead: RAMReadData.
  - Else: 32'h0.
- Input path:
  - Two-flop synchronizer sync1 <= PortIn, sync2 <= sync1.
  - last <= sync2 every cycle.
  - Rising edge of clk sets changed when |((sync2 ^ last) & EDGE_MASK).
  - Latency: a pin change is visible in PORT_IN 2 cycles later; changed sets on the 3rd edge.
- STATUS clear:
  - An IO read of offset 2 clears changed at the next edge.
  - If a new masked change is detected on that same edge, set wins and changed stays 1. No event is lost.
- Writes: MemWrite & io_sel updates the target register at the rising edge.
  - Offset 0: PORT_OUT <= WriteData.
  - Offset 3: EDGE_MASK <= WriteData[IN_WIDTH-1:0].
  - Writes to offsets 1 and 2 are ignored.
- Outputs: PortOut = PORT_OUT; InChanged = STATUS.changed.
- MemRead and MemWrite both high: write takes effect at the edge; ReadData shows the pre-write value in that cycle.
- Register state changes only via reset, a decoded write, the STATUS read-clear, or the input sampling path. Non-IO accesses never touch I/O state.

Test Plan:
- Reset low one edge, then release → PortOut=0, InChanged=0, read offset 3 (Address=32'h1001_040C) returns 32'h0000_00FF.
- Store 32'hDEAD_BEEF to 32'h1001_0400 → PortOut=32'hDEAD_BEEF next cycle, RAMMemWrite=0. Load 32'h1001_0400 → ReadData=32'hDEAD_BEEF.
- Store to 32'h1001_0010 (outside window) with data 5 → RAMMemWrite=1, PortOut unchanged. Load there with RAMReadData=5 → ReadData=5.
- PortIn 8'h00→8'h3C at cycle 0 → PORT_IN reads 32'h3C from cycle 2, InChanged=1 from cycle 3. Load STATUS → ReadData=1, InChanged=0 next cycle.
- EDGE_MASK=8'h0F, PortIn toggles only bit 7 → InChanged stays 0; PORT_IN still reflects 8'h80.
- STATUS read coinciding with a new masked change edge → InChanged remains 1. Assert reset mid-sequence → all registers return to reset values at that edge.

Source files
------------

// File: rtl/mem_io_port_unit.sv
// Memory-stage address decoder plus memory-mapped I/O block.
// It either routes a load/store to the data RAM or serves it from the port registers.
module mem_io_port_unit #(
    parameter logic [31:0] IO_BASE   = 32'h1001_0400,
    parameter int unsigned IN_WIDTH  = 8,
    parameter logic [31:0] OUT_RESET = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         Address,
    input  logic [31:0]         WriteData,
    input  logic                MemRead,
    input  logic                MemWrite,
    input  logic [31:0]         RAMReadData,
    input  logic [IN_WIDTH-1:0] PortIn,
    output logic                RAMMemRead,
    output logic                RAMMemWrite,
    output logic [31:0]         ReadData,
    output logic [31:0]         PortOut,
    output logic                InChanged
);

    localparam int unsigned DATA_W   = 32;
    localparam logic [1:0]  OFF_OUT  = 2'd0;
    localparam logic [1:0]  OFF_IN   = 2'd1;
    localparam logic [1:0]  OFF_STAT = 2'd2;
    localparam logic [1:0]  OFF_MASK = 2'd3;

    logic [DATA_W-1:0]   r_port_out;
    logic [IN_WIDTH-1:0] r_sync1;
    logic [IN_WIDTH-1:0] r_sync2;
    logic [IN_WIDTH-1:0] r_last;
    logic [IN_WIDTH-1:0] r_edge_mask;
    logic                r_changed;

    logic                w_io_sel;
    logic [1:0]          w_off;
    logic                w_io_rd;
    logic                w_io_wr;
    logic                w_stat_rd;
    logic                w_change;
    logic [DATA_W-1:0]   w_io_rdata;
    logic                w_unused_addr;

    // Only whole-word accesses exist, so the byte offset carries no information.
    assign w_unused_addr = &{1'b0, Address[1:0]};

    assign w_io_sel  = (Address[31:4] == IO_BASE[31:4]);
    assign w_off     = Address[3:2];
    assign w_io_rd   = MemRead & w_io_sel;
    assign w_io_wr   = MemWrite & w_io_sel;
    assign w_stat_rd = w_io_rd & (w_off == OFF_STAT);
    assign w_change  = |((r_sync2 ^ r_last) & r_edge_mask);

    assign RAMMemRead  = MemRead & ~w_io_sel;
    assign RAMMemWrite = MemWrite & ~w_io_sel;

    // Register read mux; reads always see the pre-write value.
    always_comb begin
        w_io_rdata = '0;
        case (w_off)
            OFF_OUT:  w_io_rdata = r_port_out;
            OFF_IN:   w_io_rdata = DATA_W'(r_sync2);
            OFF_STAT: w_io_rdata = DATA_W'(r_changed);
            OFF_MASK: w_io_rdata = DATA_W'(r_edge_mask);
            default:  w_io_rdata = '0;
        endcase
    end

    always_comb begin
        ReadData = '0;
        if (w_io_rd) begin
            ReadData = w_io_rdata;
        end else if (MemRead) begin
            ReadData = RAMReadData;
        end
    end

    // Input synchronizer, change detector and writable registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_port_out  <= OUT_RESET;
            r_sync1     <= '0;
            r_sync2     <= '0;
            r_last      <= '0;
            r_edge_mask <= '1;
            r_changed   <= 1'b0;
        end else begin
            r_sync1 <= PortIn;
            r_sync2 <= r_sync1;
            r_last  <= r_sync2;
            // A fresh event on the same edge as a STATUS read must survive.
            if (w_change) begin
                r_changed <= 1'b1;
            end else if (w_stat_rd) begin
                r_changed <= 1'b0;
            end
            if (w_io_wr && (w_off == OFF_OUT)) begin
                r_port_out <= WriteData;
            end
            if (w_io_wr && (w_off == OFF_MASK)) begin
                r_edge_mask <= WriteData[IN_WIDTH-1:0];
            end
        end
    end

    assign PortOut   = r_port_out;
    assign InChanged = r_changed;

endmodule

// File: tb/tb_mem_io_port_unit.sv
// Directed bench for mem_io_port_unit: a register-map model checks every cycle,
// literal expectations pin the key scenarios.
module tb_mem_io_port_unit;

    localparam logic [31:0] IO_BASE = 32'h1001_0400;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] RAMReadData;
    logic [7:0]  PortIn;
    logic        RAMMemRead;
    logic        RAMMemWrite;
    logic [31:0] ReadData;
    logic [31:0] PortOut;
    logic        InChanged;

    int checks = 0;
    int errors = 0;

    mem_io_port_unit #(
        .IO_BASE  (IO_BASE),
        .IN_WIDTH (8),
        .OUT_RESET(32'h0000_0000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .Address    (Address),
        .WriteData  (WriteData),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .RAMReadData(RAMReadData),
        .PortIn     (PortIn),
        .RAMMemRead (RAMMemRead),
        .RAMMemWrite(RAMMemWrite),
        .ReadData   (ReadData),
        .PortOut    (PortOut),
        .InChanged  (InChanged)
    );

    always #5 clk = ~clk;

    // Model state: register map contents plus the history of pin samples
    // (m_hist[0] = most recent edge's sample).
    logic [31:0] m_out;
    logic [7:0]  m_mask;
    logic        m_chg;
    logic [7:0]  m_hist [3];
    logic        m_valid = 1'b0;

    function automatic logic in_window(input logic [31:0] a);
        return a[31:4] == IO_BASE[31:4];
    endfunction

    function automatic logic [31:0] exp_read();
        logic [31:0] v;
        v = 32'h0;
        if (MemRead && in_window(Address)) begin
            case (Address[3:2])
                2'd0: v = m_out;
                2'd1: v = {24'h0, m_hist[1]};
                2'd2: v = {31'h0, m_chg};
                default: v = {24'h0, m_mask};
            endcase
        end else if (MemRead) begin
            v = RAMReadData;
        end
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        logic det;
        logic sel;
        if (!reset) begin
            m_out   = 32'h0;
            m_mask  = 8'hFF;
            m_chg   = 1'b0;
            m_hist  = '{8'h00, 8'h00, 8'h00};
            m_valid = 1'b1;
        end else if (m_valid) begin
            det = |((m_hist[1] ^ m_hist[2]) & m_mask);
            sel = in_window(Address);
            if (det) m_chg = 1'b1;
            else if (MemRead && sel && Address[3:2] == 2'd2) m_chg = 1'b0;
            if (MemWrite && sel && Address[3:2] == 2'd0) m_out = WriteData;
            if (MemWrite && sel && Address[3:2] == 2'd3) m_mask = WriteData[7:0];
            m_hist[2] = m_hist[1];
            m_hist[1] = m_hist[0];
            m_hist[0] = PortIn;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("mdl_ReadData", ReadData, exp_read());
            chk("mdl_RAMMemRead", {31'h0, RAMMemRead}, {31'h0, MemRead & ~in_window(Address)});
            chk("mdl_RAMMemWrite", {31'h0, RAMMemWrite}, {31'h0, MemWrite & ~in_window(Address)});
            chk("mdl_PortOut", PortOut, m_out);
            chk("mdl_InChanged", {31'h0, InChanged}, {31'h0, m_chg});
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle();
        MemRead  = 1'b0;
        MemWrite = 1'b0;
    endtask

    initial begin
        reset = 1'b0; Address = 32'h0; WriteData = 32'h0;
        MemRead = 1'b0; MemWrite = 1'b0; RAMReadData = 32'h0; PortIn = 8'h00;
        step(2);
        reset = 1'b1;

        // Reset state
        MemRead = 1'b1; Address = 32'h1001_040C;
        @(negedge clk);
        chk("rst_mask", ReadData, 32'h0000_00FF);
        chk("rst_portout", PortOut, 32'h0);
        chk("rst_inchanged", {31'h0, InChanged}, 32'h0);

        // I/O store and load of PORT_OUT
        step(1);
        idle(); MemWrite = 1'b1; Address = 32'h1001_0400; WriteData = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("io_wr_ramwrite", {31'h0, RAMMemWrite}, 32'h0);
        step(1);
        idle(); MemRead = 1'b1;
        @(negedge clk);
        chk("io_wr_portout", PortOut, 32'hDEAD_BEEF);
        chk("io_rd_portout", ReadData, 32'hDEAD_BEEF);

        // RAM store/load outside the window, including the first address past it
        step(1);
        idle(); MemWrite = 1'b1; Address = 32'h1001_0010; WriteData = 32'h5;
        @(negedge clk);
        chk("ram_wr_ramwrite", {31'h0, RAMMemWrite}, 32'h1);
        step(1);
        idle(); MemRead = 1'b1; RAMReadData = 32'h5;
        @(negedge clk);
        chk("ram_rd_data", ReadData, 32'h5);
        chk("ram_rd_portout", PortOut, 32'hDEAD_BEEF);
        step(1);
        idle(); MemWrite = 1'b1; Address = 32'h1001_0410; WriteData = 32'h7;
        @(negedge clk);
        chk("edge_addr_ramwrite", {31'h0, RAMMemWrite}, 32'h1);

        // Input change latency and STATUS read-clear
        step(1);
        idle(); PortIn = 8'h3C;
        step(2);
        MemRead = 1'b1; Address = 32'h1001_0404;
        @(negedge clk);
        chk("portin_lat2", ReadData, 32'h3C);
        chk("chg_not_yet", {31'h0, InChanged}, 32'h0);
        step(1);
        Address = 32'h1001_0408;
        @(negedge clk);
        chk("chg_set_edge3", {31'h0, InChanged}, 32'h1);
        chk("status_rd", ReadData, 32'h1);
        step(1);
        idle();
        @(negedge clk);
        chk("status_cleared", {31'h0, InChanged}, 32'h0);

        // Masked-off bit toggles do not set the flag
        step(1);
        MemWrite = 1'b1; Address = 32'h1001_040C; WriteData = 32'hFFFF_FF0F;
        step(1);
        idle(); PortIn = 8'hBC;
        step(4);
        MemRead = 1'b1; Address = 32'h1001_0404;
        @(negedge clk);
        chk("masked_portin", ReadData, 32'hBC);
        chk("masked_nochg", {31'h0, InChanged}, 32'h0);
        step(1);
        Address = 32'h1001_040F;
        @(negedge clk);
        chk("mask_readback", ReadData, 32'h0F);

        // STATUS read on the same edge a new masked change lands: set wins
        step(1);
        idle(); PortIn = 8'hBD;
        step(2);
        MemRead = 1'b1; Address = 32'h1001_0408;
        @(negedge clk);
        chk("coll_pre", ReadData, 32'h0);
        step(1);
        idle();
        @(negedge clk);
        chk("coll_set_wins", {31'h0, InChanged}, 32'h1);
        step(1);
        MemRead = 1'b1; Address = 32'h1001_0408;
        step(1);
        idle();
        @(negedge clk);
        chk("coll_then_clear", {31'h0, InChanged}, 32'h0);

        // Simultaneous read and write: read shows the old value
        step(1);
        MemRead = 1'b1; MemWrite = 1'b1; Address = 32'h1001_0400; WriteData = 32'h1234_5678;
        @(negedge clk);
        chk("rw_old_value", ReadData, 32'hDEAD_BEEF);
        step(1);
        idle();
        @(negedge clk);
        chk("rw_new_value", PortOut, 32'h1234_5678);

        // Writes to read-only offsets are ignored
        step(1);
        MemWrite = 1'b1; Address = 32'h1001_0408; WriteData = 32'hFFFF_FFFF;
        step(1);
        idle();
        @(negedge clk);
        chk("ro_write_ignored", {31'h0, InChanged}, 32'h0);

        // Mid-sequence reset with a pending flag and a coincident store
        step(1);
        PortIn = 8'hBC;
        step(3);
        @(negedge clk);
        chk("pre_reset_chg", {31'h0, InChanged}, 32'h1);
        step(1);
        reset = 1'b0; MemWrite = 1'b1; Address = 32'h1001_0400; WriteData = 32'hAAAA_5555;
        step(1);
        reset = 1'b1; idle(); MemRead = 1'b1; Address = 32'h1001_0404;
        @(negedge clk);
        chk("mid_rst_portout", PortOut, 32'h0);
        chk("mid_rst_chg", {31'h0, InChanged}, 32'h0);
        chk("mid_rst_portin", ReadData, 32'h0);
        step(1);
        Address = 32'h1001_040C;
        @(negedge clk);
        chk("mid_rst_mask", ReadData, 32'hFF);
        step(1);
        idle();
        step(4);
        @(negedge clk);
        chk("post_rst_rechg", {31'h0, InChanged}, 32'h1);

        step(1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
